// File: rtl/line_steering_controller.sv
// line_steering_controller: three-sensor line follower with a registered
// steering FSM and per-wheel PWM generation.
// Optional feature macro: LINE_STEERING_SEARCH_EN. When defined, a lost line
// times out into a spin toward the last seen side. When undefined, the
// timeout stops both wheels and the direction outputs stay forward.
module line_steering_controller #(
  parameter logic [15:0] PWM_PERIOD   = 16'd1000,
  parameter logic [15:0] FAST_DUTY    = 16'd800,
  parameter logic [15:0] SLOW_DUTY    = 16'd300,
  parameter logic [15:0] LOST_TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensorLeft,
  input  logic       sensorCenter,
  input  logic       sensorRight,
  output logic       motorLeftPwm,
  output logic       motorRightPwm,
  output logic       motorLeftDir,
  output logic       motorRightDir,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FORWARD    = 3'd0,
    VEER_LEFT  = 3'd1,
    VEER_RIGHT = 3'd2,
    LOST       = 3'd3,
    SEARCH     = 3'd4,
    STOP       = 3'd5
  } stateT;

`ifdef LINE_STEERING_SEARCH_EN
  localparam stateT TIMEOUT_STATE = SEARCH;
`else
  localparam stateT TIMEOUT_STATE = STOP;
`endif

  stateT       curState, nextState, mappedState;
  logic [2:0]  lcr;
  logic        patNone;
  logic [15:0] lostCount, lostNext;
  logic [15:0] pwmCount;
  logic        wrapNow;
  logic [15:0] tgtLeft, tgtRight, heldLeft, heldRight;
  logic        tgtDirLeft, tgtDirRight;
  logic [15:0] dutyLeft, dutyRight;
  logic        dirLeft, dirRight;
`ifdef LINE_STEERING_SEARCH_EN
  logic        lastDirRight;  // 0 = LEFT, 1 = RIGHT
`endif

  assign lcr     = {sensorLeft, sensorCenter, sensorRight};
  assign patNone = (lcr == 3'b000);
  assign state   = curState;

  // Sensor pattern to steering state; 101 and 000 keep the current state here
  always_comb begin
    mappedState = curState;
    case (lcr)
      3'b010, 3'b111: mappedState = FORWARD;
      3'b100, 3'b110: mappedState = VEER_LEFT;
      3'b001, 3'b011: mappedState = VEER_RIGHT;
      default:        mappedState = curState;
    endcase
  end

  // Next-state and lost-line counter update
  always_comb begin
    nextState = STOP;
    lostNext  = '0;
    case (curState)
      FORWARD, VEER_LEFT, VEER_RIGHT: begin
        if (patNone) begin
          nextState = LOST;
          lostNext  = 16'd1;
        end else begin
          nextState = mappedState;
        end
      end
      LOST: begin
        if (patNone) begin
          // Counter saturates at the timeout, so >= only differs from == when
          // the timeout is 0, where it avoids a permanent LOST lock-up.
          nextState = (lostCount >= LOST_TIMEOUT) ? TIMEOUT_STATE : LOST;
          lostNext  = (lostCount >= LOST_TIMEOUT) ? LOST_TIMEOUT : lostCount + 16'd1;
        end else begin
          nextState = mappedState;
        end
      end
      SEARCH, STOP: nextState = patNone ? curState : mappedState;
      default:      nextState = STOP;
    endcase
  end

  // FSM state and lost counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      curState  <= STOP;
      lostCount <= '0;
    end else begin
      curState  <= nextState;
      lostCount <= lostNext;
    end
  end

`ifdef LINE_STEERING_SEARCH_EN
  // Remember the side of the most recent veer for the search spin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lastDirRight <= 1'b0;
    else if (nextState == VEER_LEFT)
      lastDirRight <= 1'b0;
    else if (nextState == VEER_RIGHT)
      lastDirRight <= 1'b1;
  end
`endif

  // Duty/direction targets of the registered state; LOST reuses the held pair
  always_comb begin
    tgtLeft     = '0;
    tgtRight    = '0;
    tgtDirLeft  = 1'b1;
    tgtDirRight = 1'b1;
    case (curState)
      FORWARD:    begin tgtLeft = FAST_DUTY; tgtRight = FAST_DUTY; end
      VEER_LEFT:  begin tgtLeft = SLOW_DUTY; tgtRight = FAST_DUTY; end
      VEER_RIGHT: begin tgtLeft = FAST_DUTY; tgtRight = SLOW_DUTY; end
      LOST:       begin tgtLeft = heldLeft;  tgtRight = heldRight; end
`ifdef LINE_STEERING_SEARCH_EN
      SEARCH: begin
        tgtLeft     = SLOW_DUTY;
        tgtRight    = SLOW_DUTY;
        tgtDirLeft  = lastDirRight;
        tgtDirRight = ~lastDirRight;
      end
`endif
      default: begin tgtLeft = '0; tgtRight = '0; end
    endcase
  end

  // Track the last targets so LOST can keep driving them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      heldLeft  <= '0;
      heldRight <= '0;
    end else begin
      heldLeft  <= tgtLeft;
      heldRight <= tgtRight;
    end
  end

  assign wrapNow = (PWM_PERIOD <= 16'd1) || (pwmCount >= PWM_PERIOD - 16'd1);

  // Frame counter; latched duty/dir only change at the frame boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwmCount  <= '0;
      dutyLeft  <= '0;
      dutyRight <= '0;
      dirLeft   <= 1'b1;
      dirRight  <= 1'b1;
    end else if (wrapNow) begin
      pwmCount  <= '0;
      dutyLeft  <= tgtLeft;
      dutyRight <= tgtRight;
      dirLeft   <= tgtDirLeft;
      dirRight  <= tgtDirRight;
    end else begin
      pwmCount  <= pwmCount + 16'd1;
    end
  end

  assign motorLeftPwm  = (pwmCount < dutyLeft);
  assign motorRightPwm = (pwmCount < dutyRight);
  assign motorLeftDir  = dirLeft;
  assign motorRightDir = dirRight;

endmodule

// File: tb/tb_line_steering_controller.sv
// Self-checking bench for line_steering_controller with PERIOD=10, FAST=8,
// SLOW=3, TIMEOUT=20. Expectations follow LINE_STEERING_SEARCH_EN when set.
module tb_line_steering_controller;

  logic clk = 1'b0;
  logic reset_n;
  logic sL, sC, sR;
  logic pwmL, pwmR, dirL, dirR;
  logic [2:0] st;

  always #5 clk = ~clk;

  line_steering_controller #(
    .PWM_PERIOD  (16'd10),
    .FAST_DUTY   (16'd8),
    .SLOW_DUTY   (16'd3),
    .LOST_TIMEOUT(16'd20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sensorLeft   (sL),
    .sensorCenter (sC),
    .sensorRight  (sR),
    .motorLeftPwm (pwmL),
    .motorRightPwm(pwmR),
    .motorLeftDir (dirL),
    .motorRightDir(dirR),
    .state        (st)
  );

`ifdef LINE_STEERING_SEARCH_EN
  localparam int EXP_TO    = 4;
  localparam int EXP_SDUTY = 3;
  localparam int EXP_SDIRL = 0;
`else
  localparam int EXP_TO    = 5;
  localparam int EXP_SDUTY = 0;
  localparam int EXP_SDIRL = 1;
`endif

  typedef struct {
    logic [2:0] lcr;
    int         expState;
  } vecT;

  vecT tbl [16];
  int passCnt  = 0;
  int totalCnt = 0;
  int n = 0;
  int hl, hr;

  task automatic chk(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic setLcr(input logic [2:0] v);
    {sL, sC, sR} = v;
  endtask

  task automatic runFrame(output int cl, output int cr);
    cl = 0;
    cr = 0;
    repeat (10) begin
      tick();
      cl += int'(pwmL);
      cr += int'(pwmR);
    end
  endtask

  initial begin
    tbl[0]  = '{3'b111, 0};
    tbl[1]  = '{3'b110, 1};
    tbl[2]  = '{3'b101, 1};
    tbl[3]  = '{3'b011, 2};
    tbl[4]  = '{3'b101, 2};
    tbl[5]  = '{3'b100, 1};
    tbl[6]  = '{3'b001, 2};
    tbl[7]  = '{3'b010, 0};
    tbl[8]  = '{3'b101, 0};
    tbl[9]  = '{3'b000, 3};
    tbl[10] = '{3'b101, 3};
    tbl[11] = '{3'b000, 3};
    tbl[12] = '{3'b111, 0};
    tbl[13] = '{3'b011, 2};
    tbl[14] = '{3'b000, 3};
    tbl[15] = '{3'b110, 1};

    // Reset state
    reset_n = 1'b0;
    setLcr(3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(st), 5);
    chk("reset_pwmL", int'(pwmL), 0);
    chk("reset_pwmR", int'(pwmR), 0);
    chk("reset_dirL", int'(dirL), 1);
    chk("reset_dirR", int'(dirR), 1);

    // Forward
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    setLcr(3'b010);
    n = 0;
    tick();
    chk("fwd_state", int'(st), 0);
    repeat (8) tick();
    runFrame(hl, hr);
    chk("fwd_dutyL", hl, 8);
    chk("fwd_dutyR", hr, 8);

    // Veer left mid-frame: duty change waits for the wrap
    repeat (4) tick();
    setLcr(3'b110);
    tick();
    chk("vl_state", int'(st), 1);
    hl = int'(pwmL);
    hr = int'(pwmR);
    repeat (5) begin
      tick();
      hl += int'(pwmL);
      hr += int'(pwmR);
    end
    chk("vl_partialL", hl, 4);
    chk("vl_partialR", hr, 4);
    runFrame(hl, hr);
    chk("vl_dutyL", hl, 3);
    chk("vl_dutyR", hr, 8);

    // Lost line and timeout
    setLcr(3'b100);
    tick();
    chk("lost_pre_state", int'(st), 1);
    setLcr(3'b000);
    hl = 0;
    hr = 0;
    for (int k = 1; k <= 29; k++) begin
      tick();
      if (k >= 10 && k <= 19) begin
        hl += int'(pwmL);
        hr += int'(pwmR);
      end
      if (k == 1 || k == 20) chk("lost_state", int'(st), 3);
      if (k == 21 || k == 29) chk("timeout_state", int'(st), EXP_TO);
    end
    chk("lost_heldL", hl, 3);
    chk("lost_heldR", hr, 8);
    runFrame(hl, hr);
    chk("to_dutyL", hl, EXP_SDUTY);
    chk("to_dutyR", hr, EXP_SDUTY);
    chk("to_dirL", int'(dirL), EXP_SDIRL);
    chk("to_dirR", int'(dirR), 1);

    // Recovery to veer right
    setLcr(3'b001);
    tick();
    chk("vr_state", int'(st), 2);
    repeat (9) tick();
    runFrame(hl, hr);
    chk("vr_dutyL", hl, 8);
    chk("vr_dutyR", hr, 3);
    chk("vr_dirL", int'(dirL), 1);
    chk("vr_dirR", int'(dirR), 1);

    // Hold on 101, then asynchronous reset mid-frame
    setLcr(3'b101);
    tick();
    chk("hold_state", int'(st), 2);
    repeat (2) tick();
    chk("pre_rst_pwmL", int'(pwmL), 1);
    chk("pre_rst_pwmR", int'(pwmR), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_pwmL", int'(pwmL), 0);
    chk("async_rst_pwmR", int'(pwmR), 0);
    chk("async_rst_state", int'(st), 5);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    setLcr(3'b010);
    n = 0;
    tick();
    chk("post_rst_state", int'(st), 0);
    hl = int'(pwmL);
    hr = int'(pwmR);
    repeat (8) begin
      tick();
      hl += int'(pwmL);
      hr += int'(pwmR);
    end
    chk("post_rst_frame0L", hl, 0);
    chk("post_rst_frame0R", hr, 0);
    tick();
    chk("post_rst_wrapL", int'(pwmL), 1);
    chk("post_rst_wrapR", int'(pwmR), 1);

    // Sensor map table
    for (int i = 0; i < 16; i++) begin
      setLcr(tbl[i].lcr);
      tick();
      chk($sformatf("tbl%0d_state", i), int'(st), tbl[i].expState);
    end

    // Non-000 pattern in LOST restarts the timeout count
    setLcr(3'b000);
    repeat (10) tick();
    chk("clr_lost_state", int'(st), 3);
    setLcr(3'b101);
    tick();
    chk("clr_hold_state", int'(st), 3);
    setLcr(3'b000);
    for (int m = 1; m <= 21; m++) begin
      tick();
      if (m == 20) chk("clr_before_to", int'(st), 3);
      if (m == 21) chk("clr_at_to", int'(st), EXP_TO);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
